// File: rtl/axi3_rd_arbiter_if.sv
// AXI3 read-channel bundle (AR + R) used by every requester and by the shared memory port.
interface axi3_rd_if #(
  parameter int BUS_WIDTH = 4
);
  logic [BUS_WIDTH-1:0] arid;
  logic [31:0]          araddr;
  logic [3:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;
  logic [BUS_WIDTH-1:0] rid;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi3_rd_arbiter.sv
// Shares one AXI3 read port among N_MASTER requesters, one whole burst at a time.
// Round-robin by default; define AXI3_RD_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module axi3_rd_arbiter #(
  parameter int N_MASTER  = 3,
  parameter int BUS_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axi3_rd_if.slave                    m_rd [N_MASTER],
  axi3_rd_if.master                   s_rd,
  output logic [$clog2(N_MASTER)-1:0] grant_o,
  output logic                        busy_o,
  output logic                        err_o
);
  localparam int GW = $clog2(N_MASTER);
  localparam int CW = GW + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state_q;
  logic [3:0]           len_q;
  logic [3:0]           beat_q;
  logic [GW-1:0]        pick;
  logic                 ar_hs;
  logic                 r_hs;

  logic [N_MASTER-1:0]  req;
  logic [N_MASTER-1:0]  rready_v;
  logic [BUS_WIDTH-1:0] arid_v    [N_MASTER];
  logic [31:0]          araddr_v  [N_MASTER];
  logic [3:0]           arlen_v   [N_MASTER];
  logic [2:0]           arsize_v  [N_MASTER];
  logic [1:0]           arburst_v [N_MASTER];

  // Flatten the interface array so the granted master can be selected by a variable index.
  for (genvar g = 0; g < N_MASTER; g++) begin : g_master
    logic sel;
    assign sel          = (grant_o == GW'(g));
    assign req[g]       = m_rd[g].arvalid;
    assign rready_v[g]  = m_rd[g].rready;
    assign arid_v[g]    = m_rd[g].arid;
    assign araddr_v[g]  = m_rd[g].araddr;
    assign arlen_v[g]   = m_rd[g].arlen;
    assign arsize_v[g]  = m_rd[g].arsize;
    assign arburst_v[g] = m_rd[g].arburst;

    assign m_rd[g].arready = (state_q == ADDR) && sel && s_rd.arready;
    assign m_rd[g].rvalid  = (state_q == DATA) && sel && s_rd.rvalid;
    assign m_rd[g].rlast   = (state_q == DATA) && sel && s_rd.rlast;
    assign m_rd[g].rid     = s_rd.rid;
    assign m_rd[g].rdata   = s_rd.rdata;
    assign m_rd[g].rresp   = s_rd.rresp;
  end

  assign s_rd.arvalid = (state_q == ADDR) && req[grant_o];
  assign s_rd.arid    = arid_v[grant_o];
  assign s_rd.araddr  = araddr_v[grant_o];
  assign s_rd.arlen   = arlen_v[grant_o];
  assign s_rd.arsize  = arsize_v[grant_o];
  assign s_rd.arburst = arburst_v[grant_o];
  assign s_rd.rready  = (state_q == DATA) && rready_v[grant_o];

  assign ar_hs = s_rd.arvalid && s_rd.arready;
  assign r_hs  = s_rd.rvalid && s_rd.rready;

`ifdef AXI3_RD_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      if (req[k]) pick = GW'(k);
    end
  end
`else
  logic [GW-1:0] ptr_q;
  logic [CW-1:0] cand;
  logic          found;

  // Search starts at ptr_q and wraps, so the master after the last winner goes first.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      cand = CW'(ptr_q) + CW'(k);
      if (cand >= CW'(N_MASTER)) cand = cand - CW'(N_MASTER);
      if (!found && req[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == DATA && r_hs && s_rd.rlast) begin
      ptr_q <= (grant_o == GW'(N_MASTER - 1)) ? '0 : grant_o + GW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_o <= '0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_o <= pick;
            busy_o  <= 1'b1;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          len_q  <= arlen_v[grant_o];
          beat_q <= '0;
          if (ar_hs) state_q <= DATA;
        end
        DATA: begin
          if (r_hs) begin
            if (beat_q != 4'hF) beat_q <= beat_q + 4'd1;
            // RLAST must coincide exactly with the beat numbered arlen.
            if (s_rd.rlast != (beat_q == len_q)) err_o <= 1'b1;
            if (s_rd.rlast) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
